// File: rtl/elevator_scheduler.sv
// SCAN-style elevator scheduler: latches floor calls, sequences motor and door phases,
// and tracks the current floor from a per-floor travel timer.
module elevator_scheduler #(
   parameter int unsigned NUM_FLOORS    = 8,
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32,
   parameter int unsigned CLOSE_CYCLES  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic                  door_hold,
   output logic                  motor_up,
   output logic                  motor_down,
   output logic                  open_door,
   output logic                  close_door,
   output logic [3:0]            floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int unsigned NF = NUM_FLOORS;
   localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
   localparam int unsigned CW = $clog2(CLOSE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE_UP,
      S_MOVE_DOWN,
      S_DOOR_OPEN,
      S_DOOR_CLOSE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    floor_q, floor_d;
   logic [NF-1:0] pending_q, pending_d;
   logic          dir_up_q, dir_up_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [CW-1:0] ccnt_q, ccnt_d;

   logic [NF-1:0] cur_oh, up_oh, dn_oh, above_mask, below_mask, clear;
   logic          any_above, any_below, travel_done;

   logic motor_up_q, motor_down_q, open_door_q, close_door_q, busy_q;

   // Next-state, counters and request bookkeeping
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_up_d  = dir_up_q;
      tcnt_d    = tcnt_q;
      dcnt_d    = dcnt_q;
      ccnt_d    = ccnt_q;
      clear     = '0;

      cur_oh      = NF'(1) << floor_q;
      up_oh       = cur_oh << 1;
      dn_oh       = cur_oh >> 1;
      below_mask  = cur_oh - NF'(1);
      above_mask  = ~(up_oh - NF'(1));
      any_above   = |(pending_q & above_mask);
      any_below   = |(pending_q & below_mask);
      travel_done = (tcnt_q == TW'(TRAVEL_CYCLES - 1));

      case (state_q)
         S_IDLE: begin
            if (|(pending_q & cur_oh)) begin
               state_d = S_DOOR_OPEN;
               dcnt_d  = DW'(DOOR_CYCLES);
            end else if (any_above && (dir_up_q || !any_below)) begin
               state_d  = S_MOVE_UP;
               dir_up_d = 1'b1;
               tcnt_d   = '0;
            end else if (any_below) begin
               state_d  = S_MOVE_DOWN;
               dir_up_d = 1'b0;
               tcnt_d   = '0;
            end
         end
         S_MOVE_UP: begin
            if (travel_done) begin
               tcnt_d  = '0;
               floor_d = floor_q + 4'd1;
               if (|(pending_q & up_oh)) begin
                  state_d = S_DOOR_OPEN;
                  dcnt_d  = DW'(DOOR_CYCLES);
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_MOVE_DOWN: begin
            if (travel_done) begin
               tcnt_d  = '0;
               floor_d = floor_q - 4'd1;
               if (|(pending_q & dn_oh)) begin
                  state_d = S_DOOR_OPEN;
                  dcnt_d  = DW'(DOOR_CYCLES);
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_DOOR_OPEN: begin
            if (door_hold) begin
               dcnt_d = DW'(DOOR_CYCLES);
            end else if (dcnt_q <= DW'(1)) begin
               state_d = S_DOOR_CLOSE;
               dcnt_d  = '0;
               ccnt_d  = CW'(CLOSE_CYCLES);
            end else begin
               dcnt_d = dcnt_q - DW'(1);
            end
         end
         S_DOOR_CLOSE: begin
            // A fresh call for this floor reopens the door before it finishes closing
            if (|(call_req & cur_oh)) begin
               state_d = S_DOOR_OPEN;
               dcnt_d  = DW'(DOOR_CYCLES);
               ccnt_d  = '0;
            end else if (ccnt_q <= CW'(1)) begin
               state_d = S_IDLE;
               ccnt_d  = '0;
            end else begin
               ccnt_d = ccnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_DOOR_OPEN || state_q == S_DOOR_OPEN || state_q == S_DOOR_CLOSE) begin
         clear = NF'(1) << floor_d;
      end
      pending_d = (pending_q | call_req) & ~clear;
   end

   // State and Moore output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         floor_q      <= 4'd0;
         pending_q    <= '0;
         dir_up_q     <= 1'b1;
         tcnt_q       <= '0;
         dcnt_q       <= '0;
         ccnt_q       <= '0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
         open_door_q  <= 1'b0;
         close_door_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         floor_q      <= floor_d;
         pending_q    <= pending_d;
         dir_up_q     <= dir_up_d;
         tcnt_q       <= tcnt_d;
         dcnt_q       <= dcnt_d;
         ccnt_q       <= ccnt_d;
         motor_up_q   <= (state_d == S_MOVE_UP);
         motor_down_q <= (state_d == S_MOVE_DOWN);
         open_door_q  <= (state_d == S_DOOR_OPEN);
         close_door_q <= (state_d != S_DOOR_OPEN);
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign motor_up   = motor_up_q;
   assign motor_down = motor_down_q;
   assign open_door  = open_door_q;
   assign close_door = close_door_q;
   assign floor      = floor_q;
   assign pending    = pending_q;
   assign busy       = busy_q;

endmodule
